// File: rtl/sub16_seq.sv
// sub16_seq: multi-cycle 16-bit subtractor, one SLICE_W-bit slice per clock, valid/ready in and out.
// Define SUB16_SEQ_FLAGS_EN to add registered zero/neg result flags.
module sub16_seq #(
  parameter int SLICE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        Bout,
  output logic        ovf
`ifdef SUB16_SEQ_FLAGS_EN
  ,
  output logic        zero,
  output logic        neg
`endif
);
  localparam int NSLICE = 16 / SLICE_W;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] a_q, b_q, diff_nx;
  logic [3:0] cnt, lo;
  logic [SLICE_W:0] sum;
  logic borrow, last;
  // Borrow-subtract as add of the inverted subtrahend; carry-out low means a borrow.
  always_comb begin
    lo = 4'(int'(cnt) * SLICE_W);
    sum = {1'b0, a_q[lo +: SLICE_W]} + {1'b0, ~b_q[lo +: SLICE_W]} + {{SLICE_W{1'b0}}, ~borrow};
    diff_nx = diff;
    diff_nx[lo +: SLICE_W] = sum[SLICE_W-1:0];
    last = cnt == 4'(NSLICE - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE && in_valid)  ? CALC :
               (state == CALC && last)      ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      borrow <= 1'b0;
      cnt <= '0;
      diff <= '0;
      Bout <= 1'b0;
      ovf <= 1'b0;
`ifdef SUB16_SEQ_FLAGS_EN
      zero <= 1'b0;
      neg <= 1'b0;
`endif
    end else if (in_valid && in_ready) begin
      a_q <= A;
      b_q <= B;
      borrow <= Bin;
      cnt <= '0;
    end else if (state == CALC) begin
      diff <= diff_nx;
      borrow <= ~sum[SLICE_W];
      cnt <= cnt + 4'd1;
      if (last) begin
        Bout <= ~sum[SLICE_W];
        ovf <= (a_q[15] ^ b_q[15]) & (diff_nx[15] ^ a_q[15]);
`ifdef SUB16_SEQ_FLAGS_EN
        zero <= diff_nx == 16'h0000;
        neg <= diff_nx[15];
`endif
      end
    end
endmodule

// File: tb/tb_sub16_seq.sv
// tb_sub16_seq: checks sub16_seq at every legal SLICE_W against a plain-arithmetic subtraction model.
module tb_sub16_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, Bin = 0;
  logic [15:0] A = 0, B = 0;
  logic [4:0] ir, ov, bo, of;
  logic [15:0] df [5];
`ifdef SUB16_SEQ_FLAGS_EN
  logic [4:0] zr, ng;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : gi
    sub16_seq #(.SLICE_W(1 << g)) u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .A(A), .B(B), .Bin(Bin), .out_valid(ov[g]), .out_ready(out_ready),
      .diff(df[g]), .Bout(bo[g]), .ovf(of[g])
`ifdef SUB16_SEQ_FLAGS_EN
      , .zero(zr[g]), .neg(ng[g])
`endif
    );
  end

  // One full operation on instance i; the handshake completes only if out_ready is high.
  task automatic op(input int i, input logic [15:0] a, input logic [15:0] b, input logic bin, input string nm);
    logic [15:0] ed;
    logic eb, eo;
    int n;
    ed = 16'((int'(a) - int'(b) - int'(bin)) & 32'hFFFF);
    eb = int'(a) < int'(b) + int'(bin);
    eo = (a[15] != b[15]) && (ed[15] != a[15]);
    A = a; B = b; Bin = bin; in_valid = 1;
    n = 0;
    while (!ir[i] && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!ir[i]) begin
      failures++;
      $display("FAIL %s sw=%0d accept timeout in_ready=%b want 1", nm, 1 << i, ir[i]);
      in_valid = 0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 0; A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    n = 1;
    while (!ov[i] && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != (16 >> i) + 1) begin failures++; $display("FAIL %s sw=%0d latency got %0d want %0d", nm, 1 << i, n, (16 >> i) + 1); end
    checks++;
    if (df[i] !== ed) begin failures++; $display("FAIL %s sw=%0d diff got %h want %h", nm, 1 << i, df[i], ed); end
    checks++;
    if (bo[i] !== eb) begin failures++; $display("FAIL %s sw=%0d Bout got %b want %b", nm, 1 << i, bo[i], eb); end
    checks++;
    if (of[i] !== eo) begin failures++; $display("FAIL %s sw=%0d ovf got %b want %b", nm, 1 << i, of[i], eo); end
`ifdef SUB16_SEQ_FLAGS_EN
    checks++;
    if (zr[i] !== (ed == 0)) begin failures++; $display("FAIL %s sw=%0d zero got %b want %b", nm, 1 << i, zr[i], ed == 0); end
    checks++;
    if (ng[i] !== ed[15]) begin failures++; $display("FAIL %s sw=%0d neg got %b want %b", nm, 1 << i, ng[i], ed[15]); end
`endif
    if (out_ready) begin
      @(posedge clk); #1;
      checks++;
      if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
        failures++;
        $display("FAIL %s sw=%0d after handshake out_valid=%b in_ready=%b want 0/1", nm, 1 << i, ov[i], ir[i]);
      end
    end
  endtask

  task automatic test_basic;
    out_ready = 1;
    op(2, 16'hFF00, 16'h00FF, 1'b0, "basic");
    op(2, 16'h0000, 16'h0001, 1'b0, "borrow_chain_b");
    op(2, 16'h0000, 16'h0000, 1'b1, "borrow_chain_bin");
    op(2, 16'h8000, 16'h0001, 1'b0, "signed_ovf");
    op(2, 16'h03C3, 16'h00CF, 1'b1, "bin_mix");
    op(2, 16'h7FFF, 16'hFFFF, 1'b0, "both_wrap");
  endtask

  task automatic test_reset;
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    in_valid = 1'($urandom); out_ready = 1'($urandom);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    checks++;
    if (ir !== 5'h1F) begin failures++; $display("FAIL reset in_ready got %b want 11111", ir); end
    checks++;
    if (ov !== 5'h00) begin failures++; $display("FAIL reset out_valid got %b want 00000", ov); end
    checks++;
    if (bo !== 5'h00 || of !== 5'h00) begin failures++; $display("FAIL reset Bout=%b ovf=%b want 0", bo, of); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (df[i] !== 16'h0) begin failures++; $display("FAIL reset sw=%0d diff got %h want 0000", 1 << i, df[i]); end
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1; rst_n = 1;
  endtask

  task automatic test_random;
    out_ready = 1;
    for (int k = 0; k < 20; k++)
      op(2, 16'($urandom), 16'($urandom), 1'($urandom), "random");
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 3; k++)
        op(i, 16'($urandom), 16'($urandom), 1'($urandom), "random_sw");
  endtask

  task automatic test_backpressure;
    logic [15:0] hd, na, nb;
    logic hb, hv, nbin;
    out_ready = 0;
    op(2, 16'($urandom), 16'($urandom), 1'($urandom), "bp_first");
    hd = df[2]; hb = bo[2]; hv = of[2];
    na = 16'($urandom); nb = 16'($urandom); nbin = 1'($urandom);
    A = na; B = nb; Bin = nbin; in_valid = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ov[2] !== 1'b1 || ir[2] !== 1'b0) begin
        failures++;
        $display("FAIL backpressure cyc=%0d out_valid=%b in_ready=%b want 1/0", k, ov[2], ir[2]);
      end
      checks++;
      if (df[2] !== hd || bo[2] !== hb || of[2] !== hv) begin
        failures++;
        $display("FAIL backpressure hold diff=%h Bout=%b ovf=%b want %h/%b/%b", df[2], bo[2], of[2], hd, hb, hv);
      end
    end
    out_ready = 1;
    op(2, na, nb, nbin, "bp_next");
  endtask

  task automatic test_reset_mid_calc;
    int seen;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      checks++;
      if (ir[i] !== 1'b1) begin failures++; $display("FAIL midcalc sw=%0d idle in_ready got %b want 1", 1 << i, ir[i]); end
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom); in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      seen = ov[i] ? 1 : 0;
      if ((16 >> i) >= 2) begin @(posedge clk); #1; seen += ov[i] ? 1 : 0; end
      rst_n = 0;
      #1;
      seen += ov[i] ? 1 : 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      for (int k = 0; k < 20; k++) begin @(posedge clk); #1; seen += ov[i] ? 1 : 0; end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL midcalc sw=%0d aborted out_valid samples got %0d want 0", 1 << i, seen); end
      op(i, 16'h1234, 16'h1234, 1'b0, "after_abort");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_basic();
    test_reset();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
